// File: rtl/uart_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_pkg
//  Description : Shared constants for the UART/ALU sequencer: frame layout,
//                frame opcodes, sequencer state encoding, ALU operator codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_alu_pkg;

    // Received frame layout: [9:8] opcode, [7:0] payload
    localparam int c_FRAME_W  = 10;
    localparam int c_OPC_MSB  = 9;
    localparam int c_OPC_LSB  = 8;
    localparam int c_PAY_MSB  = 7;
    localparam int c_PAY_LSB  = 0;
    localparam int c_PAY_W    = c_PAY_MSB - c_PAY_LSB + 1;

    // Frame opcodes
    localparam logic [1:0] OPC_CLR = 2'b00;
    localparam logic [1:0] OPC_A   = 2'b01;
    localparam logic [1:0] OPC_B   = 2'b10;
    localparam logic [1:0] OPC_OP  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EXEC    = 2'd1,
        ST_SEND    = 2'd2,
        ST_WAIT_TX = 2'd3
    } state_t;

    // ALU operator codes shared with the ALU
    localparam logic [5:0] c_ALU_ADD = 6'h20;
    localparam logic [5:0] c_ALU_SUB = 6'h22;
    localparam logic [5:0] c_ALU_AND = 6'h24;
    localparam logic [5:0] c_ALU_OR  = 6'h25;
    localparam logic [5:0] c_ALU_XOR = 6'h26;
    localparam logic [5:0] c_ALU_NOR = 6'h27;
    localparam logic [5:0] c_ALU_SRA = 6'h03;
    localparam logic [5:0] c_ALU_SRL = 6'h02;

    // Field extraction helpers
    function automatic logic [1:0] frame_opcode(input logic [c_FRAME_W-1:0] frame);
        return frame[c_OPC_MSB:c_OPC_LSB];
    endfunction

    function automatic logic [c_PAY_W-1:0] frame_payload(input logic [c_FRAME_W-1:0] frame);
        return frame[c_PAY_MSB:c_PAY_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_alu_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_timeout
//  Description : Idle counter. Counts while enabled, restarts on clear or when
//                disabled, pulses o_expired on the cycle the count reaches
//                TIMEOUT_CYCLES-1. TIMEOUT_CYCLES = 0 disables expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_timeout #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign o_expired = 1'b0;
        end else begin : g_counter
            localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

            logic [c_CNT_W-1:0] r_count;
            logic               w_hit;

            // A clear in the same cycle as the terminal count suppresses expiry
            assign w_hit     = i_enable && !i_clear && (r_count == c_LAST);
            assign o_expired = w_hit;

            // Idle counter: restarts on clear, expiry or whenever counting is not enabled
            always_ff @(posedge i_clk) begin
                if (i_reset || i_clear || w_hit || !i_enable) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_ctrl
//  Description : Sequencer between UART RX, ALU and UART TX. Collects operand
//                A, operand B and the operator from received frames, runs the
//                ALU for one cycle, and hands the result to the transmitter.
//                Optional feature macro: UART_ALU_CTRL_KEEP_OPERANDS_EN
//                (keep operand valid flags after transmission so a single new
//                field triggers a recompute).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [9:0]         i_rx_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_dropped
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_va;
    logic               r_vb;
    logic               r_vop;
    logic               w_va_nxt;
    logic               w_vb_nxt;
    logic               w_vop_nxt;
    logic               w_all_nxt;

    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_dropped;

    logic               w_collect;
    logic               w_rx_take;
    logic [1:0]         w_opc;
    logic [c_PAY_W-1:0] w_payload;
    logic               w_tmo_enable;
    logic               w_tmo_expired;
    logic               w_tx_start;
    logic               w_busy;

    assign w_opc     = frame_opcode(i_rx_data);
    assign w_payload = frame_payload(i_rx_data);
    assign w_collect = (r_state == ST_COLLECT);
    // Frames are only accepted while collecting; anything else is dropped
    assign w_rx_take = i_rx_done && w_collect;

    // Idle timer runs only while an operand set is partially filled
    assign w_tmo_enable = w_collect && (r_va || r_vb || r_vop) && !(r_va && r_vb && r_vop);

    uart_alu_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (i_rx_done),
        .i_enable  (w_tmo_enable),
        .o_expired (w_tmo_expired)
    );

    // Next valid-flag values: received frame beats timeout, timeout beats hold
    always_comb begin
        w_va_nxt  = r_va;
        w_vb_nxt  = r_vb;
        w_vop_nxt = r_vop;
        if (w_rx_take) begin
            case (w_opc)
                OPC_CLR: begin
                    w_va_nxt  = 1'b0;
                    w_vb_nxt  = 1'b0;
                    w_vop_nxt = 1'b0;
                end
                OPC_A:   w_va_nxt  = 1'b1;
                OPC_B:   w_vb_nxt  = 1'b1;
                OPC_OP:  w_vop_nxt = 1'b1;
            endcase
        end else if (w_collect && w_tmo_expired) begin
            w_va_nxt  = 1'b0;
            w_vb_nxt  = 1'b0;
            w_vop_nxt = 1'b0;
`ifndef UART_ALU_CTRL_KEEP_OPERANDS_EN
        end else if ((r_state == ST_WAIT_TX) && i_tx_done) begin
            w_va_nxt  = 1'b0;
            w_vb_nxt  = 1'b0;
            w_vop_nxt = 1'b0;
`endif
        end
    end

    assign w_all_nxt = w_va_nxt && w_vb_nxt && w_vop_nxt;

    // Valid-flag registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_va  <= 1'b0;
            r_vb  <= 1'b0;
            r_vop <= 1'b0;
        end else begin
            r_va  <= w_va_nxt;
            r_vb  <= w_vb_nxt;
            r_vop <= w_vop_nxt;
        end
    end

    // Operand/operator field registers, loaded from accepted frames
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_rx_take) begin
            case (w_opc)
                OPC_A:   r_alu_a  <= NB_DATA'(w_payload);
                OPC_B:   r_alu_b  <= NB_DATA'(w_payload);
                OPC_OP:  r_alu_op <= w_payload[NB_OP-1:0];
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_tx_start  = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_COLLECT: begin
                w_busy = 1'b0;
                // Enter EXEC on the same edge that completes the set
                if (w_rx_take && w_all_nxt) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_tx_start  = 1'b1;
                w_state_nxt = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    // Result capture at the end of the EXEC cycle; held until the next EXEC
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_data <= '0;
        end else if (r_state == ST_EXEC) begin
            r_tx_data <= i_alu_result;
        end
    end

    // Drop indication one cycle after a frame arrives while busy
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= i_rx_done && !w_collect;
        end
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = w_tx_start;
    assign o_busy     = w_busy;
    assign o_dropped  = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_alu_ctrl
//  Description : Directed self-checking bench for uart_alu_ctrl with a small
//                ALU model and TX handshake driven from the test tasks.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_alu_ctrl;
    import uart_alu_pkg::*;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TMO     = 100;

    logic               tb_clk = 1'b0;
    logic               reset;
    logic               rx_done;
    logic [9:0]         rx_data;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_start;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_done;
    logic               busy;
    logic               dropped;

    int checks = 0;
    int errors = 0;
    int tx_start_cnt = 0;

    uart_alu_ctrl #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk        (tb_clk),
        .i_reset      (reset),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .i_tx_done    (tx_done),
        .o_busy       (busy),
        .o_dropped    (dropped)
    );

    always #5 tb_clk = ~tb_clk;

    // Reference ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            6'h27:   alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
    end

    // Count tx_start pulses, sampled mid-cycle
    initial begin
        forever begin
            @(negedge tb_clk);
            if (tx_start === 1'b1) tx_start_cnt++;
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input logic [1:0] opc, input logic [7:0] pay);
        rx_data = {opc, pay};
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Called in the EXEC cycle; walks EXEC -> SEND -> WAIT_TX -> COLLECT and
    // reports what was seen along the way
    task automatic observe_tx(output logic s_exec, output logic s_send,
                              output logic [7:0] data, output logic busy_after);
        s_exec = tx_start;
        tick();
        s_send = tx_start;
        data   = tx_data;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        busy_after = busy;
    endtask

    task automatic test_reset();
        checks++;
        if ({tx_start, busy, dropped} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got start/busy/drop=%b required 000", {tx_start, busy, dropped});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, tx_data} !== 30'd0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h op=%h tx=%h required all 0", alu_a, alu_b, alu_op, tx_data);
        end
    endtask

    task automatic test_add();
        logic se, ss, ba;
        logic [7:0] d;
        int c0;
        c0 = tx_start_cnt;
        send_frame(OPC_A,  8'h55);
        send_frame(OPC_B,  8'h03);
        send_frame(OPC_OP, 8'h20);
        checks++;
        if ({alu_a, alu_b, alu_op} !== {8'h55, 8'h03, 6'h20}) begin
            errors++;
            $display("FAIL add_operands: got a=%h b=%h op=%h required 55 03 20", alu_a, alu_b, alu_op);
        end
        observe_tx(se, ss, d, ba);
        checks++;
        if ({se, ss} !== 2'b01) begin
            errors++;
            $display("FAIL add_latency: got exec/send start=%b required 01", {se, ss});
        end
        checks++;
        if (d !== 8'h58) begin
            errors++;
            $display("FAIL add_result: got %h required 58", d);
        end
        checks++;
        if (ba !== 1'b0 || (tx_start_cnt - c0) !== 1) begin
            errors++;
            $display("FAIL add_single_start: got busy=%b starts=%0d required 0 1", ba, tx_start_cnt - c0);
        end
    endtask

    task automatic test_keep_operands();
        int c0;
        c0 = tx_start_cnt;
        send_frame(OPC_A, 8'h01);
`ifdef UART_ALU_CTRL_KEEP_OPERANDS_EN
        begin
            logic se, ss, ba;
            logic [7:0] d;
            observe_tx(se, ss, d, ba);
            checks++;
            if (ss !== 1'b1 || d !== 8'h04) begin
                errors++;
                $display("FAIL keep_recompute: got start=%b data=%h required 1 04", ss, d);
            end
        end
`else
        idle(4);
        checks++;
        if ((tx_start_cnt - c0) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL keep_off_no_start: got starts=%0d busy=%b required 0 0", tx_start_cnt - c0, busy);
        end
`endif
    endtask

    task automatic test_order();
        logic se, ss, ba;
        logic [7:0] d;
        send_frame(OPC_CLR, 8'h00);
        send_frame(OPC_OP,  8'h22);
        send_frame(OPC_B,   8'h30);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL order_partial: got busy=%b required 0", busy);
        end
        send_frame(OPC_A, 8'h10);
        observe_tx(se, ss, d, ba);
        checks++;
        if ({se, ss} !== 2'b01 || d !== 8'hE0) begin
            errors++;
            $display("FAIL order_sub: got start=%b data=%h required 01 e0", {se, ss}, d);
        end
    endtask

    task automatic test_drop();
        logic se, ss, ba;
        logic [7:0] d;
        send_frame(OPC_CLR, 8'h00);
        send_frame(OPC_A,   8'h07);
        send_frame(OPC_B,   8'h02);
        send_frame(OPC_OP,  8'h20);
        tick();
        // tx_done while in SEND must be ignored
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_txdone_in_send: got busy=%b required 1", busy);
        end
        send_frame(OPC_A, 8'hFF);
        checks++;
        if (dropped !== 1'b1 || alu_a !== 8'h07) begin
            errors++;
            $display("FAIL drop_pulse: got dropped=%b a=%h required 1 07", dropped, alu_a);
        end
        tick();
        checks++;
        if (dropped !== 1'b0 || tx_data !== 8'h09) begin
            errors++;
            $display("FAIL drop_after: got dropped=%b tx=%h required 0 09", dropped, tx_data);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        send_frame(OPC_CLR, 8'h00);
        send_frame(OPC_A,   8'h04);
        send_frame(OPC_B,   8'h0C);
        send_frame(OPC_OP,  8'h26);
        observe_tx(se, ss, d, ba);
        checks++;
        if (ss !== 1'b1 || d !== 8'h08 || ba !== 1'b0) begin
            errors++;
            $display("FAIL drop_next_result: got start=%b data=%h busy=%b required 1 08 0", ss, d, ba);
        end
    endtask

    task automatic test_timeout();
        int c0;
        send_frame(OPC_CLR, 8'h00);
        send_frame(OPC_A,   8'h11);
        idle(TMO);
        c0 = tx_start_cnt;
        send_frame(OPC_B,  8'h22);
        send_frame(OPC_OP, 8'h20);
        idle(4);
        checks++;
        if ((tx_start_cnt - c0) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clears: got starts=%0d busy=%b required 0 0", tx_start_cnt - c0, busy);
        end
    endtask

    task automatic test_timeout_edge();
        logic se, ss, ba;
        logic [7:0] d;
        send_frame(OPC_CLR, 8'h00);
        send_frame(OPC_A,   8'h40);
        // next frame lands on the expiry cycle itself
        idle(TMO - 1);
        send_frame(OPC_B,  8'h02);
        send_frame(OPC_OP, 8'h20);
        observe_tx(se, ss, d, ba);
        checks++;
        if (ss !== 1'b1 || d !== 8'h42) begin
            errors++;
            $display("FAIL timeout_frame_wins: got start=%b data=%h required 1 42", ss, d);
        end
    endtask

    task automatic test_abort_and_reset();
        int c0;
        send_frame(OPC_CLR, 8'h00);
        send_frame(OPC_A,   8'h01);
        send_frame(OPC_B,   8'h02);
        send_frame(OPC_CLR, 8'h00);
        c0 = tx_start_cnt;
        send_frame(OPC_OP,  8'h20);
        idle(4);
        checks++;
        if ((tx_start_cnt - c0) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_start: got starts=%0d busy=%b required 0 0", tx_start_cnt - c0, busy);
        end
        send_frame(OPC_A, 8'h03);
        send_frame(OPC_B, 8'h04);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || tx_data !== 8'h07) begin
            errors++;
            $display("FAIL reset_prewait: got busy=%b tx=%h required 1 07", busy, tx_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({tx_start, busy, dropped} !== 3'b000 || {alu_a, alu_b, alu_op, tx_data} !== 30'd0) begin
            errors++;
            $display("FAIL reset_in_wait: got start/busy/drop=%b a=%h b=%h op=%h tx=%h required all 0",
                     {tx_start, busy, dropped}, alu_a, alu_b, alu_op, tx_data);
        end
        c0 = tx_start_cnt;
        send_frame(OPC_OP, 8'h20);
        idle(4);
        checks++;
        if ((tx_start_cnt - c0) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags_cleared: got starts=%0d busy=%b required 0 0", tx_start_cnt - c0, busy);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = '0;
        tx_done = 1'b0;
        idle(3);
        test_reset();
        reset = 1'b0;
        tick();
        test_reset();
        test_add();
        test_keep_operands();
        test_order();
        test_drop();
        test_timeout();
        test_timeout_edge();
        test_abort_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
